// File: rtl/cla16_mp_seq.sv
// Multi-word add/sub sequencer around an external cla16; result word k is registered 1 cycle after its operand handshake,
// in_ready stalls on a full output register. Define CLA16_MP_SEQ_ZERO_EN to build the all-words-zero flag.
module cla16_mp_seq #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          sub,
   input  logic [CW-1:0] nwords,
   output logic          busy,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_a,
   input  logic [15:0]   in_b,
   output logic [15:0]   add_a,
   output logic [15:0]   add_b,
   output logic          add_cin,
   input  logic [15:0]   add_sum,
   input  logic          add_g,
   input  logic          add_p,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   out_sum,
   output logic          out_last,
   output logic          done,
   output logic          cout,
   output logic          ovf,
   output logic          zero
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t        r_state;
   logic          r_sub;
   logic [CW-1:0] r_nwords;
   logic [CW-1:0] r_wcnt;
   logic          r_carry;
   logic [15:0]   r_out_sum;
   logic          r_out_valid;
   logic          r_out_last;
   logic          r_done;
   logic          r_cout;
   logic          r_ovf;

   logic          w_c16;
   logic          w_hs;
   logic          w_out_take;
   logic          w_ovf;
   logic          w_last;

   assign busy       = (r_state != S_IDLE);
   assign in_ready   = (r_state == S_RUN) & (~r_out_valid | out_ready);
   assign add_a      = in_a;
   assign add_b      = r_sub ? ~in_b : in_b;
   assign add_cin    = r_carry;
   assign w_c16      = add_g | (add_p & r_carry);
   assign w_hs       = in_valid & in_ready;
   assign w_out_take = r_out_valid & out_ready;
   // Carry into bit 15 recovered from the sum bit; overflow is its mismatch with the word carry.
   assign w_ovf      = w_c16 ^ (add_sum[15] ^ in_a[15] ^ add_b[15]);
   assign w_last     = (r_wcnt == r_nwords);

   assign out_valid  = r_out_valid;
   assign out_sum    = r_out_sum;
   assign out_last   = r_out_last;
   assign done       = r_done;
   assign cout       = r_cout;
   assign ovf        = r_ovf;

`ifdef CLA16_MP_SEQ_ZERO_EN
   logic r_zero_acc;
   assign zero = r_zero_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_zero_acc <= 1'b0;
      else if (r_state == S_IDLE && start)
         r_zero_acc <= 1'b1;
      else if (w_hs)
         r_zero_acc <= r_zero_acc & (add_sum == 16'h0000);
   end
`else
   assign zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sub       <= 1'b0;
         r_nwords    <= '0;
         r_wcnt      <= '0;
         r_carry     <= 1'b0;
         r_out_sum   <= 16'h0000;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sub    <= sub;
                  r_nwords <= nwords;
                  r_carry  <= sub;
                  r_wcnt   <= '0;
                  r_cout   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_out_take)
                  r_out_valid <= 1'b0;
               if (w_hs) begin
                  r_out_sum   <= add_sum;
                  r_out_valid <= 1'b1;
                  r_carry     <= w_c16;
                  r_wcnt      <= r_wcnt + {{(CW-1){1'b0}}, 1'b1};
                  if (w_last) begin
                     r_out_last <= 1'b1;
                     r_cout     <= w_c16;
                     r_ovf      <= w_ovf;
                     r_state    <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (w_out_take) begin
                  r_done      <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla16_mp_seq.sv
// Directed and randomised bench for cla16_mp_seq; a behavioural cla16 closes the adder loop.
module tb_cla16_mp_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sub;
   logic [2:0]  nwords;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_g;
   logic        add_p;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_last;
   logic        done;
   logic        cout;
   logic        ovf;
   logic        zero;

   int n_checks = 0;
   int n_fail   = 0;

   logic [16:0] w_gsum;
   logic [16:0] w_fsum;
   assign w_gsum  = {1'b0, add_a} + {1'b0, add_b};
   assign w_fsum  = w_gsum + {16'h0000, add_cin};
   assign add_sum = w_fsum[15:0];
   assign add_g   = w_gsum[16];
   assign add_p   = &(add_a ^ add_b);

   cla16_mp_seq #(.CW(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .nwords(nwords), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_g(add_g), .add_p(add_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
      .done(done), .cout(cout), .ovf(ovf), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one operation; reports what the DUT produced plus protocol violations seen on the way.
   task automatic run_op(input bit s, input bit [2:0] nw, input bit [127:0] a, input bit [127:0] b,
                         input int vprob, input int rprob, input int stall_word, input int glitch_cyc,
                         output bit [127:0] res, output bit co, output bit ov, output bit z,
                         output int nout, output int ndone, output int nviol, output int nstall,
                         output bit timeout);
      int idx;
      int stall_cnt;
      int after;
      bit held;
      logic [15:0] hsum;
      res = '0; co = 0; ov = 0; z = 0; nout = 0; ndone = 0; nviol = 0; nstall = 0; timeout = 0;
      idx = 0; stall_cnt = 0; after = -1; held = 0; hsum = 16'h0;
      @(negedge clk);
      start = 1; sub = s; nwords = nw; in_valid = 0; out_ready = 0;
      @(negedge clk);
      start = 0; sub = ~s; nwords = ~nw;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == glitch_cyc) begin
            start = 1; sub = ~s; nwords = nw ^ 3'b101;
         end else begin
            start = 0;
         end
         if (idx <= int'(nw) && $urandom_range(99) < vprob) begin
            in_valid = 1; in_a = a[idx*16 +: 16]; in_b = b[idx*16 +: 16];
         end else begin
            in_valid = 0; in_a = 16'($urandom); in_b = 16'($urandom);
         end
         if (out_valid && nout == stall_word && stall_cnt < 3) begin
            out_ready = 0; stall_cnt++;
         end else begin
            out_ready = ($urandom_range(99) < rprob);
         end
         #1;
         if (held && (!out_valid || out_sum !== hsum)) nviol++;
         if (out_valid && !out_ready && in_ready) nviol++;
         if (out_valid && !out_ready) begin
            nstall++; held = 1; hsum = out_sum;
         end else begin
            held = 0;
         end
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) begin
            if (nout <= int'(nw)) res[nout*16 +: 16] = out_sum;
            if (out_last !== (nout == int'(nw))) nviol++;
            nout++;
         end
         if (done) begin
            ndone++;
            if (after < 0) begin
               after = 0; co = cout; ov = ovf; z = zero;
            end
         end
         if (after >= 0) begin
            after++;
            if (after > 3) break;
         end
         @(negedge clk);
      end
      if (after < 0) timeout = 1;
      start = 0; in_valid = 0; out_ready = 0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_last !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
      n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if ({cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {cout, ovf, zero}); end
      n_checks++; if (out_sum !== 16'h0000) begin n_fail++; $display("FAIL reset_out_sum got %h want 0000", out_sum); end
      n_checks++; if (add_cin !== 1'b0)   begin n_fail++; $display("FAIL reset_carry got %b want 0", add_cin); end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_two_word_add();
      bit [127:0] r; bit co, ov, z, to; int no, nd, nv, ns;
      run_op(0, 3'd1, 128'h0001_FFFF, 128'h0000_0001, 100, 100, -1, -1, r, co, ov, z, no, nd, nv, ns, to);
      n_checks++; if (to)    begin n_fail++; $display("FAIL add2_timeout got no done want done"); end
      n_checks++; if (r[31:0] !== 32'h0002_0000) begin n_fail++; $display("FAIL add2_words got %h want 00020000", r[31:0]); end
      n_checks++; if (co !== 1'b0 || ov !== 1'b0) begin n_fail++; $display("FAIL add2_flags got c=%b v=%b want 0 0", co, ov); end
      n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL add2_done_count got %0d want 1", nd); end
      n_checks++; if (no !== 2 || nv !== 0) begin n_fail++; $display("FAIL add2_protocol got words=%0d viol=%0d want 2 0", no, nv); end
   endtask

   task automatic test_single_word();
      bit [127:0] r; bit co, ov, z, to; int no, nd, nv, ns;
      run_op(1, 3'd0, 128'h0005, 128'h0007, 100, 100, -1, -1, r, co, ov, z, no, nd, nv, ns, to);
      n_checks++; if (to || r[15:0] !== 16'hFFFE) begin n_fail++; $display("FAIL sub_borrow_sum got %h want fffe", r[15:0]); end
      n_checks++; if (co !== 1'b0 || ov !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_flags got c=%b v=%b want 0 0", co, ov); end
      run_op(0, 3'd0, 128'h7FFF, 128'h0001, 100, 100, -1, -1, r, co, ov, z, no, nd, nv, ns, to);
      n_checks++; if (to || r[15:0] !== 16'h8000) begin n_fail++; $display("FAIL add_ovf_sum got %h want 8000", r[15:0]); end
      n_checks++; if (co !== 1'b0 || ov !== 1'b1) begin n_fail++; $display("FAIL add_ovf_flags got c=%b v=%b want 0 1", co, ov); end
      run_op(1, 3'd0, 128'h1234, 128'h1234, 100, 100, -1, -1, r, co, ov, z, no, nd, nv, ns, to);
      n_checks++; if (to || r[15:0] !== 16'h0000) begin n_fail++; $display("FAIL sub_eq_sum got %h want 0000", r[15:0]); end
      n_checks++; if (co !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL sub_eq_flags got c=%b v=%b want 1 0", co, ov); end
`ifdef CLA16_MP_SEQ_ZERO_EN
      n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL sub_eq_zero got %b want 1", z); end
`else
      n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL sub_eq_zero got %b want 0", z); end
`endif
   endtask

   task automatic test_backpressure();
      bit [127:0] r; bit co, ov, z, to; int no, nd, nv, ns;
      run_op(0, 3'd3, 128'h0123_4567_89AB_CDEF, 128'hFEDC_BA98_7654_3211, 100, 100, 1, -1,
             r, co, ov, z, no, nd, nv, ns, to);
      n_checks++; if (to || r[63:0] !== 64'h0) begin n_fail++; $display("FAIL bp_words got %h want 0", r[63:0]); end
      n_checks++; if (co !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL bp_flags got c=%b v=%b want 1 0", co, ov); end
      n_checks++; if (ns !== 3) begin n_fail++; $display("FAIL bp_stall_cycles got %0d want 3", ns); end
      n_checks++; if (nv !== 0 || no !== 4 || nd !== 1) begin n_fail++; $display("FAIL bp_protocol got viol=%0d words=%0d done=%0d want 0 4 1", nv, no, nd); end
   endtask

   task automatic test_start_in_run();
      bit [127:0] r; bit co, ov, z, to; int no, nd, nv, ns;
      run_op(0, 3'd1, 128'h1234_8000, 128'h0001_8000, 100, 100, -1, 0, r, co, ov, z, no, nd, nv, ns, to);
      n_checks++; if (to || r[31:0] !== 32'h1236_0000) begin n_fail++; $display("FAIL glitch_words got %h want 12360000", r[31:0]); end
      n_checks++; if (no !== 2 || nd !== 1 || nv !== 0) begin n_fail++; $display("FAIL glitch_protocol got words=%0d done=%0d viol=%0d want 2 1 0", no, nd, nv); end
   endtask

   task automatic test_reset_mid_op();
      int nd;
      nd = 0;
      @(negedge clk);
      start = 1; sub = 0; nwords = 3'd3; in_valid = 0; out_ready = 1;
      @(negedge clk);
      start = 0; in_valid = 1; in_a = 16'h1111; in_b = 16'h2222;
      @(negedge clk);
      #1;
      n_checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_running got busy=%b ov=%b want 1 1", busy, out_valid); end
      rst_n = 0;
      #1;
      n_checks++; if ({busy, in_ready, out_valid, out_last, done, cout, ovf, zero} !== 8'h00)
         begin n_fail++; $display("FAIL midrst_outputs got %b want 00000000", {busy, in_ready, out_valid, out_last, done, cout, ovf, zero}); end
      n_checks++; if (out_sum !== 16'h0000) begin n_fail++; $display("FAIL midrst_out_sum got %h want 0000", out_sum); end
      in_valid = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (done) nd++;
      end
      n_checks++; if (nd !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got done=%0d busy=%b want 0 0", nd, busy); end
   endtask

   task automatic test_random();
      bit [127:0] r; bit co, ov, z, to; int no, nd, nv, ns;
      logic [128:0] one, mask, full, am, bm, er;
      bit s, ec, eo, ez, sa, sb, sr;
      bit [2:0] nw;
      int w;
      for (int t = 0; t < 24; t++) begin
         s  = 1'($urandom_range(1));
         nw = 3'($urandom_range(7));
         w  = 16 * (int'(nw) + 1);
         one  = 129'd1;
         mask = (one << w) - one;
         am = {1'b0, $urandom, $urandom, $urandom, $urandom} & mask;
         bm = {1'b0, $urandom, $urandom, $urandom, $urandom} & mask;
         if (t == 0) begin am = mask; bm = s ? 129'd0 : 129'd1; end
         if (s) begin
            er = (am - bm) & mask;
            ec = (am >= bm);
         end else begin
            full = am + bm;
            er = full & mask;
            ec = full[w];
         end
         sa = am[w-1]; sb = bm[w-1]; sr = er[w-1];
         eo = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`ifdef CLA16_MP_SEQ_ZERO_EN
         ez = (er == 129'd0);
`else
         ez = 1'b0;
`endif
         run_op(s, nw, am[127:0], bm[127:0], 60, 60, -1, -1, r, co, ov, z, no, nd, nv, ns, to);
         n_checks++; if (to || r !== er[127:0]) begin n_fail++; $display("FAIL rand%0d_result got %h want %h", t, r, er[127:0]); end
         n_checks++; if ({co, ov, z} !== {ec, eo, ez}) begin n_fail++; $display("FAIL rand%0d_flags got %b want %b", t, {co, ov, z}, {ec, eo, ez}); end
         n_checks++; if (no !== int'(nw) + 1 || nd !== 1 || nv !== 0)
            begin n_fail++; $display("FAIL rand%0d_protocol got words=%0d done=%0d viol=%0d want %0d 1 0", t, no, nd, nv, int'(nw) + 1); end
      end
   endtask

   initial begin
      rst_n = 0; start = 0; sub = 0; nwords = 3'd0;
      in_valid = 0; in_a = 16'h0; in_b = 16'h0; out_ready = 0;
      test_reset();
      test_two_word_add();
      test_single_word();
      test_backpressure();
      test_start_in_run();
      test_reset_mid_op();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
